axi4_ram_slaver: RTL and testbench
==================================

AXI4_RAM_SLAVER -- requirements
Module: axi4_ram_slaver

Interface
REQ-001 Parameter IDSIZE, default 1: width of AXI ID fields.
REQ-002 Parameter ASIZE, default 8: address width; memory depth SHALL be 2**ASIZE words, word-addressed.
REQ-003 Parameter LSIZE, default 8: burst length field width; beats = len+1.
REQ-004 Parameter DSIZE, default 8: data width, one word per beat.
REQ-005 axi_aclk  input  1  single clock, carried in the axi_inf instance bound to s00.
REQ-006 axi_aresetn  input  1  asynchronous active-low reset, carried in the same axi_inf instance.
REQ-007 s00  axi_inf.slaver  modport  complete AXI4 slave port (AW/W/B/AR/R), parameters matching REQ-001..004.

Function
REQ-008 Write and read paths SHALL run as independent FSMs; one write and one read burst may be in flight concurrently.
REQ-009 Write FSM states: W_IDLE, W_DATA, W_RESP; reset state W_IDLE.
REQ-010 W_IDLE: awready=1; on awvalid&awready latch awid, awaddr, awlen, clear beat counter and error flag, go W_DATA next cycle.
REQ-011 W_DATA: wready=1, awready=0; each wvalid&wready writes wdata to mem[addr], then addr+1 mod 2**ASIZE (INCR only; burst type ignored).
REQ-012 Beat counter, not wlast, SHALL terminate the burst; after beat awlen+1 go W_RESP.
REQ-013 wlast asserted on a non-final beat, or deasserted on the final beat, SHALL set the error flag.
REQ-014 W_RESP: bvalid=1, bid=latched awid, bresp=2'b00 (OKAY) or 2'b10 (SLVERR) if error flag; hold until bready, then W_IDLE.
REQ-015 wstrb SHALL be ignored; every accepted beat is written.
REQ-016 Read FSM states: R_IDLE, R_DATA; reset state R_IDLE.
REQ-017 R_IDLE: arready=1; on arvalid&arready latch arid, araddr, arlen, go R_DATA.
REQ-018 First rvalid SHALL assert exactly 2 cycles after the AR handshake cycle (one cycle registered RAM read).
REQ-019 With rready held high, beats SHALL issue one per cycle, no bubbles; rlast=1 only on beat arlen+1.
REQ-020 rvalid&!rready: rdata, rid, rlast, rresp SHALL stay stable until accepted.
REQ-021 rresp=2'b00 always; rid=latched arid; after final handshake return to R_IDLE, arready=1 next cycle.
REQ-022 Address wrap: burst crossing 2**ASIZE-1 SHALL continue at address 0.
REQ-023 Same-cycle write and read of one address: read returns old data (read-first), write takes effect.
REQ-024 awlen=0 / arlen=0: single-beat burst, wlast/rlast on that beat.

Reset
REQ-025 While axi_aresetn=0: awready, wready, bvalid, arready, rvalid, rlast =0; bid, bresp, rid, rresp, rdata =0; both FSMs idle.
REQ-026 Reset mid-burst SHALL abandon the burst with no response; memory contents retained, not cleared.
REQ-027 First handshake accepted no earlier than first axi_aclk rising edge after reset release.

Structure
REQ-028 Package axi4_ram_slaver_pkg SHALL hold the write-state and read-state enum typedefs and the OKAY/SLVERR response constants.
REQ-029 One sub-module, simple_dpram: one write port, one registered read port, depth 2**ASIZE, width DSIZE.

Verification
REQ-030 Write addr 0x00, len 8, data 1..9 -> bresp=OKAY, bid=awid; read addr 0x00, len 8 -> rdata 1..9, rlast on 9th beat.
REQ-031 Write addr 0xFE, len 3, data A0..A3 -> read addr 0xFE len 3 returns A0,A1,A2,A3; read addr 0x00 len 1 returns A2,A3.
REQ-032 Read len 5 with rready toggled 1/0 every cycle -> 6 beats, data stable during stalls, no beat lost or duplicated.
REQ-033 Write len 3 with wlast on beat 2 -> 4 beats written, bresp=SLVERR; next clean write gives OKAY.
REQ-034 Concurrent write addr 0x10 len 7 and read addr 0x40 len 7, id 1 -> both complete, rid=1, correct data, no cross-interference.
REQ-035 Assert axi_aresetn=0 mid read burst beat 3 -> all outputs 0 same cycle; after release, arready=1 and earlier-written data still readable.

Source files
------------

// File: rtl/axi4_ram_slaver_pkg.sv
// Shared types for the AXI4 RAM slave: write/read FSM encodings and response codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi4_ram_slaver_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_inf.sv
// AXI4 bundle carrying clock, async active-low reset and all five channels.
// Latency: n/a (wiring only).
// Backpressure: standard AXI valid/ready on every channel.
// Modport slaver: clock/reset and master-driven fields in, slave responses out.
interface axi_inf #(
  parameter int IDSIZE = 1,
  parameter int ASIZE  = 8,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 8
) ();
  localparam int SSIZE = (DSIZE + 7) / 8;

  logic              axi_aclk;
  logic              axi_aresetn;

  logic [IDSIZE-1:0] awid;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DSIZE-1:0]  wdata;
  logic [SSIZE-1:0]  wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [IDSIZE-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [IDSIZE-1:0] arid;
  logic [ASIZE-1:0]  araddr;
  logic [LSIZE-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [IDSIZE-1:0] rid;
  logic [DSIZE-1:0]  rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slaver (
    input  axi_aclk, axi_aresetn,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/simple_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
// Latency: read data valid 1 cycle after rd_en; rd_dat holds while rd_en is low.
// Backpressure: none; caller stalls by holding rd_en low.
// Ports: clk/rst_n, wr_en/wr_addr/wr_dat, rd_en/rd_addr, rd_dat.
module simple_dpram #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [DSIZE-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_dat
);

  logic [DSIZE-1:0] mem [2**ASIZE];
  logic [DSIZE-1:0] rd_dat_q;

  // Array has no reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Non-blocking read of the array gives old data on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat_q <= '0;
    end else if (rd_en) begin
      rd_dat_q <= mem[rd_addr];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/axi4_ram_slaver.sv
// AXI4 slave in front of a word-addressed RAM; independent write and read burst engines.
// Latency: first R beat 2 cycles after AR handshake, then 1 beat/cycle; B 1 cycle after last W.
// Backpressure: R held stable while rready low (RAM read stalls); B held until bready.
// Ports: s00 (axi_inf.slaver) carries axi_aclk, axi_aresetn and the AW/W/B/AR/R channels.
module axi4_ram_slaver
  import axi4_ram_slaver_pkg::*;
#(
  parameter int IDSIZE = 1,
  parameter int ASIZE  = 8,
  parameter int LSIZE  = 8,
  parameter int DSIZE  = 8
) (
  axi_inf.slaver s00
);

  logic clk;
  logic rst_n;
  assign clk   = s00.axi_aclk;
  assign rst_n = s00.axi_aresetn;

  // Burst type, size and strobes do not affect behaviour.
  logic unused_fields;
  assign unused_fields = ^{s00.awsize, s00.awburst, s00.wstrb, s00.arsize, s00.arburst};

  // ---------------------------------------------------------------- write path
  w_state_e          w_state_q, w_state_d;
  logic [IDSIZE-1:0] wid_q, wid_d;
  logic [ASIZE-1:0]  waddr_q, waddr_d;
  logic [LSIZE-1:0]  wlen_q, wlen_d;
  logic [LSIZE-1:0]  wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;
  logic              w_final;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    w_final   = (wcnt_q == wlen_q);

    unique case (w_state_q)
      W_IDLE: begin
        if (s00.awvalid && awready_q) begin
          wid_d     = s00.awid;
          waddr_d   = s00.awaddr;
          wlen_d    = s00.awlen;
          wcnt_d    = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s00.wvalid && wready_q) begin
          mem_we  = 1'b1;
          waddr_d = waddr_q + ASIZE'(1);
          wcnt_d  = wcnt_q + LSIZE'(1);
          // The beat count ends the burst; wlast only has to agree with it.
          if (s00.wlast != w_final) begin
            werr_d = 1'b1;
          end
          if (w_final) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s00.bready && bvalid_q) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    // Handshake outputs are registered from the next state so reset forces them low.
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = ((w_state_d == W_RESP) && werr_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e          r_state_q, r_state_d;
  logic [IDSIZE-1:0] rid_q, rid_d;
  logic [ASIZE-1:0]  raddr_q, raddr_d;
  logic [LSIZE-1:0]  rlen_q, rlen_d;
  logic [LSIZE-1:0]  rcnt_q, rcnt_d;
  logic              rdone_q, rdone_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              mem_re;
  logic [DSIZE-1:0]  ram_rd_dat;

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rdone_d   = rdone_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    mem_re    = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        if (s00.arvalid && arready_q) begin
          rid_d     = s00.arid;
          raddr_d   = s00.araddr;
          rlen_d    = s00.arlen;
          rcnt_d    = '0;
          rdone_d   = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // The RAM output register doubles as the R data register: fetch the
        // next word only when the current one is absent or leaving this cycle.
        mem_re = !rdone_q && (!rvalid_q || s00.rready);
        if (mem_re) begin
          raddr_d = raddr_q + ASIZE'(1);
          rcnt_d  = rcnt_q + LSIZE'(1);
          if (rcnt_q == rlen_q) begin
            rdone_d = 1'b1;
          end
        end
        if (rvalid_q && s00.rready && rlast_q) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (mem_re) begin
      rvalid_d = 1'b1;
      rlast_d  = (rcnt_q == rlen_q);
    end else if (rvalid_q && s00.rready) begin
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
    end

    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rdone_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rdone_q   <= rdone_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // ----------------------------------------------------------------------- RAM
  simple_dpram #(
    .ASIZE (ASIZE),
    .DSIZE (DSIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (mem_we),
    .wr_addr (waddr_q),
    .wr_dat  (s00.wdata),
    .rd_en   (mem_re),
    .rd_addr (raddr_q),
    .rd_dat  (ram_rd_dat)
  );

  // ------------------------------------------------------------------- outputs
  assign s00.awready = awready_q;
  assign s00.wready  = wready_q;
  assign s00.bvalid  = bvalid_q;
  assign s00.bid     = wid_q;
  assign s00.bresp   = bresp_q;
  assign s00.arready = arready_q;
  assign s00.rvalid  = rvalid_q;
  assign s00.rlast   = rlast_q;
  assign s00.rid     = rid_q;
  assign s00.rdata   = ram_rd_dat;
  assign s00.rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi4_ram_slaver.sv
// Testbench for axi4_ram_slaver: random and directed bursts against an array model.
// Latency: checks first R beat 2 cycles after AR and back-to-back beats with rready high.
// Backpressure: drives rready/bready stalls and wvalid gaps.
module tb_axi4_ram_slaver;

  localparam int IDSIZE = 1;
  localparam int ASIZE  = 8;
  localparam int LSIZE  = 8;
  localparam int DSIZE  = 8;
  localparam int SSIZE  = (DSIZE + 7) / 8;
  localparam int DEPTH  = 2 ** ASIZE;
  localparam int TMO    = 200;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  axi_inf #(.IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)) axi ();

  axi4_ram_slaver #(.IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE)) dut (
    .s00 (axi)
  );

  initial axi.axi_aclk = 1'b0;
  always #5 axi.axi_aclk = ~axi.axi_aclk;

  logic [DSIZE-1:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_abort(input string tag);
    check({tag, "_timeout"}, 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "bench stopped on timeout");
  endtask

  task automatic tick();
    @(posedge axi.axi_aclk);
    #1;
  endtask

  // err_beat in [0,len] flips wlast on that beat; -1 means a clean burst.
  task automatic axi_write(input int addr, input int len, input int id,
                           input logic [DSIZE-1:0] dat[$], input int err_beat, input bit slow);
    int cyc;
    bit err;
    err = (err_beat >= 0) && (err_beat <= len);
    axi.awid    = IDSIZE'(id);
    axi.awaddr  = ASIZE'(addr);
    axi.awlen   = LSIZE'(len);
    axi.awsize  = 3'd0;
    axi.awburst = 2'($urandom_range(0, 2));
    axi.awvalid = 1'b1;
    cyc = 0;
    while (!axi.awready) begin
      tick();
      if (++cyc > TMO) timeout_abort("aw");
    end
    tick();
    axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (slow) repeat ($urandom_range(0, 2)) tick();
      axi.wdata  = dat[i];
      axi.wlast  = (i == len) ^ (i == err_beat);
      axi.wstrb  = SSIZE'($urandom);
      axi.wvalid = 1'b1;
      cyc = 0;
      while (!axi.wready) begin
        tick();
        if (++cyc > TMO) timeout_abort("w");
      end
      tick();
      model_mem[(addr + i) % DEPTH] = dat[i];
      axi.wvalid = 1'b0;
      axi.wlast  = 1'b0;
    end
    cyc = 0;
    while (!axi.bvalid) begin
      tick();
      if (++cyc > TMO) timeout_abort("b");
    end
    check("bid", 32'(axi.bid), 32'(id));
    check("bresp", 32'(axi.bresp), 32'(err ? SLVERR : OKAY));
    if (slow) begin
      tick();
      tick();
      check("bvalid_hold", 32'(axi.bvalid), 32'd1);
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    check("bvalid_clr", 32'(axi.bvalid), 32'd0);
  endtask

  // mode 0: rready high; 1: rready toggles every cycle; 2: random rready.
  task automatic axi_read(input int addr, input int len, input int id, input int mode);
    int cyc;
    int beat;
    int first;
    bit stalled;
    logic [DSIZE-1:0] pdat;
    logic plast;
    axi.arid    = IDSIZE'(id);
    axi.araddr  = ASIZE'(addr);
    axi.arlen   = LSIZE'(len);
    axi.arsize  = 3'd0;
    axi.arburst = 2'($urandom_range(0, 2));
    axi.arvalid = 1'b1;
    axi.rready  = (mode == 0);
    cyc = 0;
    while (!axi.arready) begin
      tick();
      if (++cyc > TMO) timeout_abort("ar");
    end
    tick();
    axi.arvalid = 1'b0;
    cyc = 1;
    beat = 0;
    first = 0;
    stalled = 1'b0;
    pdat = '0;
    plast = 1'b0;
    while (beat <= len) begin
      if (mode == 1) axi.rready = ~axi.rready;
      else if (mode == 2) axi.rready = 1'($urandom_range(0, 1));
      if (axi.rvalid) begin
        if (first == 0) begin
          first = cyc;
          check("r_latency", 32'(first), 32'd2);
        end
        if (stalled) begin
          check("r_stable_dat", 32'(axi.rdata), 32'(pdat));
          check("r_stable_last", 32'(axi.rlast), 32'(plast));
        end
        if (axi.rready) begin
          check("rdata", 32'(axi.rdata), 32'(model_mem[(addr + beat) % DEPTH]));
          check("rlast", 32'(axi.rlast), 32'(beat == len));
          check("rid", 32'(axi.rid), 32'(id));
          check("rresp", 32'(axi.rresp), 32'(OKAY));
          if (mode == 0) check("r_no_bubble", 32'(cyc), 32'(first + beat));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pdat = axi.rdata;
          plast = axi.rlast;
        end
      end
      tick();
      cyc++;
      if (cyc > 4 * len + TMO) timeout_abort("r");
    end
    axi.rready = 1'b0;
    check("arready_ret", 32'(axi.arready), 32'd1);
    check("rvalid_clr", 32'(axi.rvalid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(axi.awready), 32'd0);
    check({tag, "_wready"},  32'(axi.wready),  32'd0);
    check({tag, "_bvalid"},  32'(axi.bvalid),  32'd0);
    check({tag, "_arready"}, 32'(axi.arready), 32'd0);
    check({tag, "_rvalid"},  32'(axi.rvalid),  32'd0);
    check({tag, "_rlast"},   32'(axi.rlast),   32'd0);
    check({tag, "_bid_bresp"}, 32'({axi.bid, axi.bresp}), 32'd0);
    check({tag, "_rid_rresp_rdata"}, 32'({axi.rid, axi.rresp, axi.rdata}), 32'd0);
  endtask

  logic [DSIZE-1:0] q[$];
  int cyc_m;

  initial begin
    axi.axi_aresetn = 1'b0;
    {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awvalid} = '0;
    {axi.wdata, axi.wstrb, axi.wlast, axi.wvalid, axi.bready} = '0;
    {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arvalid, axi.rready} = '0;

    repeat (3) tick();
    check_all_zero("reset");
    axi.axi_aresetn = 1'b1;
    tick();
    check("post_rst_awready", 32'(axi.awready), 32'd1);
    check("post_rst_arready", 32'(axi.arready), 32'd1);

    // Fill the whole RAM so every later read has a known model value.
    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(DSIZE'($urandom));
    axi_write(0, DEPTH - 1, 0, q, -1, 1'b0);

    // Basic 9-beat burst, data 1..9.
    q.delete();
    for (int i = 1; i <= 9; i++) q.push_back(DSIZE'(i));
    axi_write(8'h00, 8, 1, q, -1, 1'b0);
    axi_read(8'h00, 8, 0, 0);

    // Wrap past the top of memory.
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    axi_write(8'hFE, 3, 0, q, -1, 1'b1);
    axi_read(8'hFE, 3, 1, 0);
    axi_read(8'h00, 1, 0, 0);

    // Read with rready toggling.
    axi_read(8'h20, 5, 1, 1);

    // Early wlast gives SLVERR with all beats still written; clean burst recovers.
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    axi_write(8'h30, 3, 1, q, 1, 1'b0);
    axi_read(8'h30, 3, 0, 0);
    q = '{8'h55, 8'h66, 8'h77, 8'h88};
    axi_write(8'h30, 3, 0, q, -1, 1'b0);
    axi_read(8'h30, 3, 0, 2);

    // Single-beat bursts, including a missing wlast on the only beat.
    q = '{8'h5A};
    axi_write(8'h80, 0, 1, q, -1, 1'b0);
    axi_read(8'h80, 0, 1, 0);
    q = '{8'hC3};
    axi_write(8'h81, 0, 0, q, 0, 1'b0);
    axi_read(8'h80, 1, 0, 2);

    // Concurrent write and read on disjoint regions.
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(DSIZE'($urandom));
    fork
      axi_write(8'h10, 7, 1, q, -1, 1'b1);
      axi_read(8'h40, 7, 1, 0);
    join
    axi_read(8'h10, 7, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      int op;
      int wa;
      int wl;
      int ra;
      int rl;
      op = $urandom_range(0, 2);
      wl = $urandom_range(0, 15);
      rl = $urandom_range(0, 15);
      q.delete();
      for (int i = 0; i <= wl; i++) q.push_back(DSIZE'($urandom));
      if (op == 0) begin
        wa = $urandom_range(0, DEPTH - 1);
        axi_write(wa, wl, $urandom_range(0, 1), q,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, wl) : -1,
                  1'($urandom_range(0, 1)));
      end else if (op == 1) begin
        ra = $urandom_range(0, DEPTH - 1);
        axi_read(ra, rl, $urandom_range(0, 1), $urandom_range(0, 2));
      end else begin
        wa = $urandom_range(8'h00, 8'h6F);
        ra = $urandom_range(8'h80, 8'hEF);
        fork
          axi_write(wa, wl, 1, q, -1, 1'($urandom_range(0, 1)));
          axi_read(ra, rl, 0, $urandom_range(0, 2));
        join
      end
    end

    // Reset in the middle of a read burst, on beat index 3.
    axi.arid    = 1'b1;
    axi.araddr  = 8'h00;
    axi.arlen   = 8'd8;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    cyc_m = 0;
    while (!axi.arready) begin
      tick();
      if (++cyc_m > TMO) timeout_abort("ar_rst");
    end
    tick();
    axi.arvalid = 1'b0;
    repeat (4) tick();
    check("mid_rvalid", 32'(axi.rvalid), 32'd1);
    check("mid_rdata", 32'(axi.rdata), 32'(model_mem[3]));
    axi.axi_aresetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    axi.rready = 1'b0;
    tick();
    tick();
    axi.axi_aresetn = 1'b1;
    tick();
    check("rel_arready", 32'(axi.arready), 32'd1);
    check("rel_rvalid", 32'(axi.rvalid), 32'd0);
    axi_read(8'h00, 8, 1, 2);
    axi_read(8'hFC, 7, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
